// File: rtl/frame_err_chk_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_err_chk_if
// Description : Signal bundle for the frame error checker. The bench/driver
//               side uses the master modport and the checker uses slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_err_chk_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  // Driver -> checker
  logic              fc_clear;
  logic              fc_start;
  logic [DATA_W-1:0] data_in;
  logic [1:0]        parity_mode;
  logic              bit_valid;
  logic              bit_in;

  // Checker -> driver
  logic              busy;
  logic              check_done;
  logic              framing_error;
  logic              parity_error;
  logic [CNT_W-1:0]  frame_err_cnt;
  logic [CNT_W-1:0]  parity_err_cnt;

  modport master (
    output fc_clear, fc_start, data_in, parity_mode, bit_valid, bit_in,
    input  busy, check_done, framing_error, parity_error,
           frame_err_cnt, parity_err_cnt
  );

  modport slave (
    input  fc_clear, fc_start, data_in, parity_mode, bit_valid, bit_in,
    output busy, check_done, framing_error, parity_error,
           frame_err_cnt, parity_err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/frame_err_chk.sv
`default_nettype none
// ============================================================================
// Module      : frame_err_chk
// Description : Checks the parity bit and one or two stop bits of a received
//               character, publishes per-frame error flags and keeps
//               saturating error counters.
//               DATA_W legal range 5..9, STOP_BITS legal values 1 or 2.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_err_chk #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int CNT_W     = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  frame_err_chk_if.slave     bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PAR   = 3'd1,
    S_STOP1 = 3'd2,
    S_STOP2 = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic             C_TWO_STOP = (STOP_BITS == 2);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_odd_q, par_odd_d;   // 1 = odd parity expected
  logic              perr_q, perr_d;         // in-flight parity result
  logic              ferr_q, ferr_d;         // in-flight framing result
  logic              done_q, done_d;
  logic              framing_error_q, framing_error_d;
  logic              parity_error_q, parity_error_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  parity_cnt_q, parity_cnt_d;

  logic              w_par_en;               // mode 01 or 10 enables parity
  logic              w_par_odd;

  assign w_par_en  = (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
  assign w_par_odd = (bus.parity_mode == 2'b10);

  // Next-state and datapath decisions; fc_clear overrides the FSM at the end.
  always_comb begin
    state_d         = state_q;
    data_d          = data_q;
    par_odd_d       = par_odd_q;
    perr_d          = perr_q;
    ferr_d          = ferr_q;
    done_d          = 1'b0;
    framing_error_d = framing_error_q;
    parity_error_d  = parity_error_q;
    frame_cnt_d     = frame_cnt_q;
    parity_cnt_d    = parity_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.fc_start) begin
          data_d    = bus.data_in;
          par_odd_d = w_par_odd;
          perr_d    = 1'b0;      // stays 0 when parity is disabled
          ferr_d    = 1'b0;
          state_d   = w_par_en ? S_PAR : S_STOP1;
        end
      end

      S_PAR: begin
        if (bus.bit_valid) begin
          // Total parity of data plus parity bit must equal the odd flag.
          perr_d  = ((^data_q) ^ bus.bit_in) != par_odd_q;
          state_d = S_STOP1;
        end
      end

      S_STOP1: begin
        if (bus.bit_valid) begin
          ferr_d = ~bus.bit_in;
          if (C_TWO_STOP) begin
            state_d = S_STOP2;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_STOP2: begin
        if (bus.bit_valid) begin
          ferr_d  = ferr_q | ~bus.bit_in;
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end

      S_DONE: begin
        // Flags reflect only the frame just finished; counters saturate.
        framing_error_d = ferr_q;
        parity_error_d  = perr_q;
        if (ferr_q && (frame_cnt_q != C_CNT_MAX)) begin
          frame_cnt_d = frame_cnt_q + C_CNT_ONE;
        end
        if (perr_q && (parity_cnt_q != C_CNT_MAX)) begin
          parity_cnt_d = parity_cnt_q + C_CNT_ONE;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Clear aborts any frame in flight and wipes the visible results.
    if (bus.fc_clear) begin
      state_d         = S_IDLE;
      perr_d          = 1'b0;
      ferr_d          = 1'b0;
      done_d          = 1'b0;
      framing_error_d = 1'b0;
      parity_error_d  = 1'b0;
      frame_cnt_d     = '0;
      parity_cnt_d    = '0;
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      data_q          <= '0;
      par_odd_q       <= 1'b0;
      perr_q          <= 1'b0;
      ferr_q          <= 1'b0;
      done_q          <= 1'b0;
      framing_error_q <= 1'b0;
      parity_error_q  <= 1'b0;
      frame_cnt_q     <= '0;
      parity_cnt_q    <= '0;
    end else begin
      state_q         <= state_d;
      data_q          <= data_d;
      par_odd_q       <= par_odd_d;
      perr_q          <= perr_d;
      ferr_q          <= ferr_d;
      done_q          <= done_d;
      framing_error_q <= framing_error_d;
      parity_error_q  <= parity_error_d;
      frame_cnt_q     <= frame_cnt_d;
      parity_cnt_q    <= parity_cnt_d;
    end
  end

  assign bus.busy           = (state_q != S_IDLE);
  assign bus.check_done     = done_q;
  assign bus.framing_error  = framing_error_q;
  assign bus.parity_error   = parity_error_q;
  assign bus.frame_err_cnt  = frame_cnt_q;
  assign bus.parity_err_cnt = parity_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_err_chk.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_err_chk
// Description : Self-checking bench. Two checkers (1 stop bit / 8-bit
//               counters and 2 stop bits / 2-bit counters) share one
//               stimulus stream and are compared against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_err_chk;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fc_clear = 1'b0;
  logic       fc_start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [1:0] parity_mode = 2'b00;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;

  int tests  = 0;
  int errors = 0;

  // Frame-level model: flags of last finished frame and saturating counts.
  int m_f1 = 0, m_p1 = 0, m_fc1 = 0, m_pc1 = 0;
  int m_f2 = 0, m_p2 = 0, m_fc2 = 0, m_pc2 = 0;

  frame_err_chk_if #(.DATA_W(8), .CNT_W(8)) if1 ();
  frame_err_chk_if #(.DATA_W(8), .CNT_W(2)) if2 ();

  assign if1.fc_clear = fc_clear;    assign if2.fc_clear = fc_clear;
  assign if1.fc_start = fc_start;    assign if2.fc_start = fc_start;
  assign if1.data_in = data_in;      assign if2.data_in = data_in;
  assign if1.parity_mode = parity_mode; assign if2.parity_mode = parity_mode;
  assign if1.bit_valid = bit_valid;  assign if2.bit_valid = bit_valid;
  assign if1.bit_in = bit_in;        assign if2.bit_in = bit_in;

  frame_err_chk #(.DATA_W(8), .STOP_BITS(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );
  frame_err_chk #(.DATA_W(8), .STOP_BITS(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with random bit_in; optionally spurious fc_start pulses.
  task automatic gap(input bit inj);
    int n;
    n = $urandom_range(0, 2);
    repeat (n) begin
      bit_valid = 1'b0;
      bit_in    = 1'($urandom);
      if (inj) begin
        fc_start    = 1'b1;
        data_in     = 8'($urandom);
        parity_mode = 2'($urandom);
      end
      tick();
    end
    fc_start = 1'b0;
  endtask

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // One complete frame: parity bit (if enabled), stop1, stop2.
  // DUT1 finishes after stop1 and must ignore the stop2 strobe.
  task automatic run_frame(input logic [7:0] d, input logic [1:0] m,
                           input bit pb, input bit s1, input bit s2,
                           input bit inj);
    int ones, n;
    bit en, exp_p, exp_f1, exp_f2;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    en     = (m == 2'b01) || (m == 2'b10);
    exp_p  = en ? (((ones + int'(pb)) % 2) != ((m == 2'b10) ? 1 : 0)) : 1'b0;
    exp_f1 = !s1;
    exp_f2 = !s1 || !s2;

    fc_start = 1'b1; data_in = d; parity_mode = m;
    tick();
    fc_start = 1'b0;
    tests++; if (if1.busy !== 1'b1 || if2.busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b/%b exp 1/1", if1.busy, if2.busy); end

    if (en) begin
      gap(inj);
      bit_valid = 1'b1; bit_in = pb;
      tick();
      bit_valid = 1'b0;
    end
    gap(inj);
    bit_valid = 1'b1; bit_in = s1;
    tick();
    tests++; if (if1.check_done !== 1'b1 || if1.busy !== 1'b1) begin errors++; $display("FAIL d1_done_pulse got done=%b busy=%b exp 1/1", if1.check_done, if1.busy); end
    tests++; if (if2.check_done !== 1'b0 || if2.busy !== 1'b1) begin errors++; $display("FAIL d2_wait_stop2 got done=%b busy=%b exp 0/1", if2.check_done, if2.busy); end

    m_f1 = int'(exp_f1); m_p1 = int'(exp_p);
    if (exp_f1) m_fc1 = sat(m_fc1, 255);
    if (exp_p)  m_pc1 = sat(m_pc1, 255);

    n = $urandom_range(0, 2);
    bit_valid = (n == 0);
    bit_in    = (n == 0) ? s2 : 1'($urandom);
    tick();
    tests++; if (if1.check_done !== 1'b0 || if1.busy !== 1'b0) begin errors++; $display("FAIL d1_after_done got done=%b busy=%b exp 0/0", if1.check_done, if1.busy); end
    tests++; if (if1.framing_error !== exp_f1 || if1.parity_error !== exp_p) begin errors++; $display("FAIL d1_flags got f=%b p=%b exp f=%b p=%b", if1.framing_error, if1.parity_error, exp_f1, exp_p); end
    tests++; if (if1.frame_err_cnt !== 8'(m_fc1) || if1.parity_err_cnt !== 8'(m_pc1)) begin errors++; $display("FAIL d1_counts got %0d/%0d exp %0d/%0d", if1.frame_err_cnt, if1.parity_err_cnt, m_fc1, m_pc1); end
    if (n != 0) begin
      repeat (n - 1) begin
        bit_valid = 1'b0; bit_in = 1'($urandom);
        tick();
      end
      bit_valid = 1'b1; bit_in = s2;
      tick();
    end
    bit_valid = 1'b0;
    tests++; if (if2.check_done !== 1'b1) begin errors++; $display("FAIL d2_done_pulse got %b exp 1", if2.check_done); end

    m_f2 = int'(exp_f2); m_p2 = int'(exp_p);
    if (exp_f2) m_fc2 = sat(m_fc2, 3);
    if (exp_p)  m_pc2 = sat(m_pc2, 3);
    tick();
    tests++; if (if2.check_done !== 1'b0 || if2.busy !== 1'b0) begin errors++; $display("FAIL d2_after_done got done=%b busy=%b exp 0/0", if2.check_done, if2.busy); end
    tests++; if (if2.framing_error !== exp_f2 || if2.parity_error !== exp_p) begin errors++; $display("FAIL d2_flags got f=%b p=%b exp f=%b p=%b", if2.framing_error, if2.parity_error, exp_f2, exp_p); end
    tests++; if (if2.frame_err_cnt !== 2'(m_fc2) || if2.parity_err_cnt !== 2'(m_pc2)) begin errors++; $display("FAIL d2_counts got %0d/%0d exp %0d/%0d", if2.frame_err_cnt, if2.parity_err_cnt, m_fc2, m_pc2); end
  endtask

  task automatic test_reset();
    rst = 1'b1; fc_start = 1'b1; bit_valid = 1'b1; data_in = 8'hFF;
    tick(); tick();
    rst = 1'b0; fc_start = 1'b0; bit_valid = 1'b0;
    tests++; if (if1.busy !== 1'b0 || if2.busy !== 1'b0 || if1.check_done !== 1'b0 || if2.check_done !== 1'b0) begin errors++; $display("FAIL reset_ctrl got busy %b/%b done %b/%b exp 0", if1.busy, if2.busy, if1.check_done, if2.check_done); end
    tests++; if ({if1.framing_error, if1.parity_error, if2.framing_error, if2.parity_error} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b%b%b%b exp 0000", if1.framing_error, if1.parity_error, if2.framing_error, if2.parity_error); end
    tests++; if (if1.frame_err_cnt !== 8'd0 || if1.parity_err_cnt !== 8'd0 || if2.frame_err_cnt !== 2'd0 || if2.parity_err_cnt !== 2'd0) begin errors++; $display("FAIL reset_counts got nonzero exp 0"); end
  endtask

  task automatic test_directed();
    run_frame(8'hA5, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);  // even parity, clean
    run_frame(8'hA5, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);  // odd parity mismatch
    tests++; if (if1.parity_error !== 1'b1 || if1.parity_err_cnt !== 8'd1 || if1.framing_error !== 1'b0) begin errors++; $display("FAIL odd_parity got p=%b cnt=%0d f=%b exp 1/1/0", if1.parity_error, if1.parity_err_cnt, if1.framing_error); end
    run_frame(8'h5A, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);  // second stop bit low
    tests++; if (if2.framing_error !== 1'b1 || if2.frame_err_cnt !== 2'd1) begin errors++; $display("FAIL stop2_err got f=%b cnt=%0d exp 1/1", if2.framing_error, if2.frame_err_cnt); end
    run_frame(8'h3C, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);  // good frame, mode 11
    tests++; if (if2.framing_error !== 1'b0 || if2.frame_err_cnt !== 2'd1) begin errors++; $display("FAIL good_after_err got f=%b cnt=%0d exp 0/1", if2.framing_error, if2.frame_err_cnt); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 5; k++)
      run_frame(8'($urandom), 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    tests++; if (if2.frame_err_cnt !== 2'd3) begin errors++; $display("FAIL saturate got %0d exp 3", if2.frame_err_cnt); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++)
      run_frame(8'($urandom), 2'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) != 0), 1'($urandom));
  endtask

  task automatic test_clear_mid_frame();
    fc_start = 1'b1; data_in = 8'h81; parity_mode = 2'b00;
    tick();
    fc_start = 1'b0;
    fc_clear = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
    tick();
    fc_clear = 1'b0; bit_valid = 1'b0;
    m_f1 = 0; m_p1 = 0; m_fc1 = 0; m_pc1 = 0;
    m_f2 = 0; m_p2 = 0; m_fc2 = 0; m_pc2 = 0;
    tests++; if (if1.busy !== 1'b0 || if2.busy !== 1'b0 || if1.check_done !== 1'b0 || if2.check_done !== 1'b0) begin errors++; $display("FAIL clear_ctrl got busy %b/%b done %b/%b exp 0", if1.busy, if2.busy, if1.check_done, if2.check_done); end
    tests++; if ({if1.framing_error, if1.parity_error, if2.framing_error, if2.parity_error} !== 4'b0) begin errors++; $display("FAIL clear_flags got %b%b%b%b exp 0000", if1.framing_error, if1.parity_error, if2.framing_error, if2.parity_error); end
    tests++; if (if1.frame_err_cnt !== 8'd0 || if1.parity_err_cnt !== 8'd0 || if2.frame_err_cnt !== 2'd0 || if2.parity_err_cnt !== 2'd0) begin errors++; $display("FAIL clear_counts got %0d/%0d/%0d/%0d exp 0", if1.frame_err_cnt, if1.parity_err_cnt, if2.frame_err_cnt, if2.parity_err_cnt); end
    tick();
    tests++; if (if1.check_done !== 1'b0 || if2.check_done !== 1'b0) begin errors++; $display("FAIL clear_no_done got %b/%b exp 0/0", if1.check_done, if2.check_done); end
  endtask

  task automatic test_busy_start_and_rst();
    run_frame(8'hA5, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1);  // spurious starts ignored
    run_frame(8'h0F, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
    fc_start = 1'b1; data_in = 8'h12; parity_mode = 2'b01;
    tick();
    fc_start = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    rst = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
    tick();
    rst = 1'b0; bit_valid = 1'b0;
    m_f1 = 0; m_p1 = 0; m_fc1 = 0; m_pc1 = 0;
    m_f2 = 0; m_p2 = 0; m_fc2 = 0; m_pc2 = 0;
    tests++; if (if1.busy !== 1'b0 || if2.busy !== 1'b0 || if1.check_done !== 1'b0 || if2.check_done !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl got busy %b/%b done %b/%b exp 0", if1.busy, if2.busy, if1.check_done, if2.check_done); end
    tests++; if ({if1.framing_error, if1.parity_error, if2.framing_error, if2.parity_error} !== 4'b0 || if1.frame_err_cnt !== 8'd0 || if2.frame_err_cnt !== 2'd0 || if1.parity_err_cnt !== 8'd0 || if2.parity_err_cnt !== 2'd0) begin errors++; $display("FAIL rst_mid_state got nonzero flags or counts exp 0"); end
    run_frame(8'hC3, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_saturation();
    test_random();
    test_clear_mid_frame();
    test_busy_start_and_rst();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire
